shift_left_seq: RTL and testbench
=================================

# shift_left_seq

Multi-cycle logical left shifter (SLL/SLLI) for the pipeline execute stage. It is the left-shift counterpart of the combinational arithmetic right shifter. The operand is latched on a valid/ready handshake. The shift is then applied one power-of-two stage per cycle (1, 2, 4, 8, 16), and the result is held on a valid/ready output until the consumer accepts it. This trades the 32-way mux for a 5-cycle sequential datapath.

## Interface
- No parameters; datapath fixed at 32 bits, shift amount 5 bits.
- clk  input  1  Single clock; all state updates on rising edge.
- rst_n  input  1  Asynchronous reset, active-low.
- flush  input  1  Synchronous abort; discards any operation in flight.
- in_valid  input  1  Operand present on data_in/shift_amt.
- in_ready  output  1  Block can accept an operand; high only in IDLE.
- data_in  input  32  Operand to shift.
- shift_amt  input  5  Left-shift amount, 0..31.
- out_valid  output  1  data_out holds a completed result; high only in DONE.
- out_ready  input  1  Consumer accepts the result.
- data_out  output  32  Shifted result; zero-filled from bit 0.
- busy  output  1  High in SHIFT or DONE.

## Operation
- Registered state: acc[31:0], amt[4:0], stage counter k[2:0], and a 2-bit FSM {IDLE, SHIFT, DONE}.
- IDLE: in_ready=1.
  - On in_valid && !flush: acc<=data_in, amt<=shift_amt, k<=0, go to SHIFT.
- SHIFT: each cycle, if amt[k] then acc<=acc<<(1<<k); k<=k+1.
  - After applying stage k=4, go to DONE.
- DONE: out_valid=1; data_out=acc, held stable.
  - On out_ready go to IDLE.
  - No acceptance in DONE: no back-to-back bypass, and in_ready=0.
- flush: from any state, go to IDLE on the next edge. acc is not cleared; out_valid drops. flush wins over in_valid and out_ready in the same cycle.
- Bits shifted past bit 31 are discarded. Vacated low bits are 0. There is no sign or overflow indication.
- in_valid asserted while not IDLE is ignored. The source must hold its operand until it sees in_ready.

## Timing
- Reset values: state=IDLE, acc=0, amt=0, k=0. Outputs: in_ready=1, out_valid=0, data_out=0, busy=0.
- Reset asserted mid-operation: immediate asynchronous return to IDLE. The operation is lost and no out_valid is produced.
- Latency without the early-exit macro:
  - Accept at edge t0.
  - Stages 0..4 are applied at edges t1..t5.
  - out_valid is high in the cycle after t5, which is a fixed 5 edges after accept.
- Throughput: the next accept is possible at the earliest one edge after the out_ready handshake. Minimum 7 cycles per operation.
- in_ready, out_valid and busy are decoded directly from the state register. They have no combinational path from inputs.
- Backpressure: while out_ready=0, the block stays in DONE indefinitely with data_out constant.

## Configuration
- SHIFT_LEFT_SEQ_EARLY_EXIT_EN defined:
  - On accept with shift_amt==0, go directly to DONE with acc=data_in. out_valid is high the cycle after accept.
  - In SHIFT, after applying stage k, go to DONE if amt[4:k+1]==0.
  - Latency becomes msb_index(shift_amt)+1 edges after accept. For example, amt=1 takes 1 edge and amt=5 takes 3 edges.
- Not defined: every operation traverses all five stages, for a fixed 5-edge latency. The output value is identical in both builds.

## Test plan
- data_in=0x0000_0001, amt=31, out_ready=1:
  - Result is data_out=0x8000_0000.
  - out_valid rises 5 edges after accept, or 5 edges with early exit (MSB is bit 4).
- data_in=0xF0F0_F0F0, amt=4:
  - Result is 0x0F0F_0F00.
  - Latency is 5 edges, or 3 with early exit.
- data_in=0xDEAD_BEEF, amt=0:
  - Result is 0xDEAD_BEEF.
  - Latency is 5 edges, or 0 with early exit (out_valid in the cycle after accept).
- Backpressure: data_in=0x1234_5678, amt=8, out_ready=0 for 10 cycles after out_valid:
  - data_out stays 0x3456_7800 throughout and in_ready stays 0.
  - After out_ready=1 for one edge: out_valid=0, in_ready=1.
- flush at the second SHIFT cycle of any operation:
  - Next cycle: IDLE, in_ready=1, out_valid=0, busy=0.
  - The following accept of 0x1 with amt=3 yields 0x8.
- rst_n pulsed low mid-SHIFT:
  - All outputs return to their reset values immediately.
  - No out_valid is seen afterwards until a new accept.

Source files
------------

// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter: one power-of-two stage (1,2,4,8,16) per cycle.
// Ports: clk, rst_n (async, active-low), flush; in_valid/in_ready with data_in[31:0],
// shift_amt[4:0]; out_valid/out_ready with data_out[31:0]; busy.
// Optional: define SHIFT_LEFT_SEQ_EARLY_EXIT_EN to leave SHIFT once no higher amount bits remain.
module shift_left_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    input  logic [4:0]  shift_amt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] acc;
    logic [4:0]  amt;
    logic [2:0]  k;
    logic        accept;
    logic        last_stage;
    logic        skip_shift;

    assign accept = (state == IDLE) && in_valid && !flush;

`ifdef SHIFT_LEFT_SEQ_EARLY_EXIT_EN
    // Stop once every amount bit above the current stage is zero.
    assign last_stage = (k == 3'd4) || ((amt >> (k + 3'd1)) == 5'd0);
    assign skip_shift = (shift_amt == 5'd0);
`else
    assign last_stage = (k == 3'd4);
    assign skip_shift = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_nx = skip_shift ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_stage) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Datapath: stage k shifts by 2**k when amt[k] is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 32'd0;
            amt <= 5'd0;
            k   <= 3'd0;
        end else if (accept) begin
            acc <= data_in;
            amt <= shift_amt;
            k   <= 3'd0;
        end else if (state == SHIFT && !flush) begin
            if (amt[k]) begin
                acc <= acc << (5'd1 << k);
            end
            k <= k + 3'd1;
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == SHIFT) || (state == DONE);
    end

    assign data_out = acc;

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: directed cases, flush, async reset,
// backpressure and randomized operands against an arithmetic reference model.
module tb_shift_left_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = 32'd0;
    logic [4:0]  shift_amt = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    shift_left_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Edges from accept to out_valid, derived from the amount's highest set bit.
    function automatic int model_latency(input logic [4:0] a);
`ifdef SHIFT_LEFT_SEQ_EARLY_EXIT_EN
        if (a == 5'd0) return 0;
        for (int i = 4; i >= 0; i--) begin
            if (a[i]) return i + 1;
        end
        return 0;
`else
        return 5;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input string tag, input logic [31:0] d, input logic [4:0] a);
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        data_in   = d;
        shift_amt = a;
        step();
        in_valid  = 1'b0;
        data_in   = $urandom;
        shift_amt = 5'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] a,
                          input int hold);
        logic [31:0] exp;
        int n;
        exp = d << a;
        accept_op(tag, d, a);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, ".latency"}, n, model_latency(a));
        check({tag, ".data"}, data_out, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, ".hold_data"}, data_out, exp);
            check({tag, ".hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".post_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".post_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, ".post_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2;
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.data_out", data_out, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        run_op("msb", 32'h0000_0001, 5'd31, 0);
        run_op("nib", 32'hF0F0_F0F0, 5'd4, 0);
        run_op("zero", 32'hDEAD_BEEF, 5'd0, 0);
        run_op("one", 32'h8000_0001, 5'd1, 0);
        run_op("bp", 32'h1234_5678, 5'd8, 10);

        // Flush during the second SHIFT cycle.
        accept_op("fl", 32'hFFFF_FFFF, 5'd31);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl.in_ready", {31'd0, in_ready}, 32'd1);
        check("fl.out_valid", {31'd0, out_valid}, 32'd0);
        check("fl.busy", {31'd0, busy}, 32'd0);
        run_op("after_fl", 32'h0000_0001, 5'd3, 0);

        // Flush beats in_valid in IDLE.
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("fl_idle.busy", {31'd0, busy}, 32'd0);

        // Flush beats out_ready in DONE.
        accept_op("fl_done", 32'h0000_0003, 5'd2);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check("fl_done.valid", {31'd0, out_valid}, 32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("fl_done.out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_done.in_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-SHIFT.
        accept_op("ar", 32'hAAAA_5555, 5'd17);
        step();
        rst_n = 1'b0;
        #1;
        check("ar.in_ready", {31'd0, in_ready}, 32'd1);
        check("ar.out_valid", {31'd0, out_valid}, 32'd0);
        check("ar.busy", {31'd0, busy}, 32'd0);
        check("ar.data_out", data_out, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("ar.no_valid", {31'd0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 24; i++) begin
            run_op("rnd", $urandom, 5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
